instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the multicycle RV32I core: owns the PC, addresses the registered ROM and hands
// {instruction, PC} to decode over valid/ready. Optional perf counters under FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [31:0]       i_rom_data,
    output logic [31:0]       o_instr,
    output logic [31:0]       o_instr_pc,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       o_fetch_cnt,
    output logic [31:0]       o_stall_cnt
`endif
);

    // state | meaning
    // REQ   | PC on ROM address, ROM samples it at the closing edge
    // RESP  | ROM word for PC is on i_rom_data, capture it
    // HOLD  | instruction presented to decode, wait for ready
    // FAULT | bad PC, no fetches until redirect or reset
    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_RESP  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        pc_bad;

    assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q[31:ADDR_W] != '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;

        case (state_q)
            ST_REQ: begin
                if (pc_bad) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                instr_d    = i_rom_data;
                instr_pc_d = pc_q;
                valid_d    = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        // Redirect wins over every state; an in-flight ROM word is dropped, not captured.
        if (i_redirect) begin
            pc_d       = i_redirect_pc;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            valid_d    = 1'b0;
            err_d      = 1'b0;
            state_d    = ST_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign o_rom_addr    = pc_q[ADDR_W-1:0];
    assign o_instr       = instr_q;
    assign o_instr_pc    = instr_pc_q;
    assign o_instr_valid = valid_q;
    assign o_fetch_err   = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (valid_q && i_instr_ready) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == ST_HOLD) && !i_instr_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: registered ROM model plus a scoreboard of expected
// {instruction, PC} pairs popped whenever decode accepts an instruction.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [13:0] o_rom_addr;
    logic [31:0] i_rom_data;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (14)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .o_rom_addr    (o_rom_addr),
        .i_rom_data    (i_rom_data),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fetch_err   (o_fetch_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_fetch_cnt   (o_fetch_cnt),
        .o_stall_cnt   (o_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        case (a)
            14'h0000: rom_word = 32'h0000_2517;
            14'h0004: rom_word = 32'h71c5_0513;
            default:  rom_word = 32'hC0DE_0000 | {18'h0, a};
        endcase
    endfunction

    // Registered ROM: one cycle of latency from address to data.
    always @(posedge clk) i_rom_data <= rom_word(o_rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({rom_word(pc[13:0]), pc});
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (o_instr_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(o_instr_valid), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && o_instr_valid === 1'b1 && i_instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pc", o_instr_pc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_instr", o_instr, e[63:32]);
                check("sb_pc", o_instr_pc, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr [6];
        logic        exp_v    [6];
        exp_addr = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4};
        exp_v    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        i_instr_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 32'h0;
        repeat (3) step();
        check("rst_valid", 32'(o_instr_valid), 32'd0);
        check("rst_err", 32'(o_fetch_err), 32'd0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_instr_pc", o_instr_pc, 32'h0);
        check("rst_rom_addr", 32'(o_rom_addr), 32'h0);

        // Back-to-back fetch with ready held high: cycles 0..5.
        i_instr_ready = 1'b1;
        rst = 1'b0;
        push_exp(32'h0);
        push_exp(32'h4);
        for (int i = 0; i < 6; i++) begin
            check("seq_rom_addr", 32'(o_rom_addr), exp_addr[i]);
            check("seq_valid", 32'(o_instr_valid), 32'(exp_v[i]));
            step();
        end

        // Stall in HOLD at pc=0x8 for four cycles.
        i_instr_ready = 1'b0;
        push_exp(32'h8);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", 32'(o_instr_valid), 32'd1);
            check("stall_pc", o_instr_pc, 32'h8);
            check("stall_instr", o_instr, rom_word(14'h0008));
            step();
        end
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", o_stall_cnt, 32'd4);
`endif
        i_instr_ready = 1'b1;
        step();
        check("after_stall_addr", 32'(o_rom_addr), 32'hC);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_3", o_fetch_cnt, 32'd3);
`endif

        // Redirect to 0x40 while the 0x10 word is in flight.
        push_exp(32'hC);
        repeat (3) step();
        check("req_0x10_addr", 32'(o_rom_addr), 32'h10);
        step();
        i_redirect = 1'b1;
        i_redirect_pc = 32'h40;
        step();
        i_redirect = 1'b0;
        check("redir_addr", 32'(o_rom_addr), 32'h40);
        check("redir_valid", 32'(o_instr_valid), 32'd0);
        push_exp(32'h40);
        wait_valid("wait_0x40");
        check("pc_0x40", o_instr_pc, 32'h40);
        step();

        // Redirect to 0x1C, then redirect+ready together in HOLD.
        i_instr_ready = 1'b0;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h1C;
        step();
        i_redirect = 1'b0;
        push_exp(32'h1C);
        wait_valid("wait_0x1c");
        check("pc_0x1c", o_instr_pc, 32'h1C);
        i_instr_ready = 1'b1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h20;
        step();
        i_redirect = 1'b0;
        check("redir_hold_addr", 32'(o_rom_addr), 32'h20);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_6", o_fetch_cnt, 32'd6);
`endif
        push_exp(32'h20);
        wait_valid("wait_0x20");
        check("pc_0x20", o_instr_pc, 32'h20);
        step();

        // Misaligned target, then recovery.
        i_redirect = 1'b1;
        i_redirect_pc = 32'h22;
        step();
        i_redirect = 1'b0;
        check("mis_err_req", 32'(o_fetch_err), 32'd0);
        check("mis_addr", 32'(o_rom_addr), 32'h22);
        step();
        check("mis_err", 32'(o_fetch_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("fault_valid", 32'(o_instr_valid), 32'd0);
            check("fault_addr", 32'(o_rom_addr), 32'h22);
            step();
        end
        check("fault_err_sticky", 32'(o_fetch_err), 32'd1);
        i_redirect = 1'b1;
        i_redirect_pc = 32'h24;
        step();
        i_redirect = 1'b0;
        check("err_clear", 32'(o_fetch_err), 32'd0);
        push_exp(32'h24);
        wait_valid("wait_0x24");
        check("pc_0x24", o_instr_pc, 32'h24);
        step();

        // Out-of-range target.
        i_redirect = 1'b1;
        i_redirect_pc = 32'h4000;
        step();
        i_redirect = 1'b0;
        check("oor_err_req", 32'(o_fetch_err), 32'd0);
        check("oor_addr", 32'(o_rom_addr), 32'h0);
        step();
        check("oor_err", 32'(o_fetch_err), 32'd1);
        check("oor_valid", 32'(o_instr_valid), 32'd0);

        // Last legal word, then pc+4 walks out of range.
        i_redirect = 1'b1;
        i_redirect_pc = 32'h3FFC;
        step();
        i_redirect = 1'b0;
        push_exp(32'h3FFC);
        wait_valid("wait_0x3ffc");
        check("pc_0x3ffc", o_instr_pc, 32'h3FFC);
        step();
        check("edge_err_req", 32'(o_fetch_err), 32'd0);
        step();
        check("edge_err", 32'(o_fetch_err), 32'd1);

        // Reset while in FAULT.
        rst = 1'b1;
        step();
        check("frst_err", 32'(o_fetch_err), 32'd0);
        check("frst_addr", 32'(o_rom_addr), 32'h0);
        check("frst_valid", 32'(o_instr_valid), 32'd0);
        check("frst_instr_pc", o_instr_pc, 32'h0);
        rst = 1'b0;
        push_exp(32'h0);
        wait_valid("wait_restart");
        check("pc_restart", o_instr_pc, 32'h0);
        step();
        i_instr_ready = 1'b0;
        step();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
